// File: rtl/cnn_pool2x2_param.sv
// cnn_pool2x2_param: 2x2/stride-2 max/average pooling over CH packed channels, walking the pooled map row-major.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, pool_mode              frame start pulse; 0 = max, 1 = average (latched with start)
//   in_ee, in_eo, in_oe, in_oo    quad pixels, valid one cycle after rd_en
//   rd_en, rd_row, rd_col         quad read request and its pooled-map coordinates
//   save_en, out_row, out_col     pooled word valid and its destination coordinates
//   out_data                      pooled word, holds while save_en is low
//   busy, first_out, done         frame in progress, first word pulse, last word pulse
module cnn_pool2x2_param #(
    parameter int CH       = 8,
    parameter int DW       = 16,
    parameter int OUT_ROWS = 8,
    parameter int OUT_COLS = 8,
    parameter int AW       = 16,
    parameter int RELU     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pool_mode,
    input  logic [CH*DW-1:0]   in_ee,
    input  logic [CH*DW-1:0]   in_eo,
    input  logic [CH*DW-1:0]   in_oe,
    input  logic [CH*DW-1:0]   in_oo,
    output logic               rd_en,
    output logic [AW-1:0]      rd_row,
    output logic [AW-1:0]      rd_col,
    output logic               save_en,
    output logic [AW-1:0]      out_row,
    output logic [AW-1:0]      out_col,
    output logic [CH*DW-1:0]   out_data,
    output logic               busy,
    output logic               first_out,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam logic [AW-1:0] LAST_R = AW'(OUT_ROWS - 1);
    localparam logic [AW-1:0] LAST_C = AW'(OUT_COLS - 1);
    state_t             state_q;
    logic               mode_q;
    logic               rd_en_q;
    logic [AW-1:0]      rd_row_q;
    logic [AW-1:0]      rd_col_q;
    logic               p1_vld_q;
    logic [AW-1:0]      p1_row_q;
    logic [AW-1:0]      p1_col_q;
    logic               save_en_q;
    logic [AW-1:0]      out_row_q;
    logic [AW-1:0]      out_col_q;
    logic [CH*DW-1:0]   out_data_q;
    logic               first_q;
    logic               done_q;
    logic [CH*DW-1:0]   pool_d;
    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [DW-1:0] a, b, c, d, m0, m1, mx, r;
        logic signed [DW+1:0] s;
        assign a  = in_ee[k*DW +: DW];
        assign b  = in_eo[k*DW +: DW];
        assign c  = in_oe[k*DW +: DW];
        assign d  = in_oo[k*DW +: DW];
        assign m0 = a > b ? a : b;
        assign m1 = c > d ? c : d;
        assign mx = m0 > m1 ? m0 : m1;
        // Two guard bits make the four-way sum exact; dropping the low two bits is a floor divide by 4.
        assign s  = (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c) + (DW+2)'(d);
        assign r  = mode_q ? s[DW+1:2] : mx;
        assign pool_d[k*DW +: DW] = (RELU != 0 && r[DW-1]) ? '0 : r;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= READ;
                    mode_q   <= pool_mode;
                    rd_en_q  <= 1'b1;
                    rd_row_q <= '0;
                    rd_col_q <= '0;
                end
                READ: if (rd_row_q == LAST_R && rd_col_q == LAST_C) begin
                    state_q <= DRAIN;
                    rd_en_q <= 1'b0;
                end else begin
                    rd_col_q <= rd_col_q == LAST_C ? '0 : rd_col_q + 1'b1;
                    rd_row_q <= rd_col_q == LAST_C ? rd_row_q + 1'b1 : rd_row_q;
                end
                // The last word leaving the pipe is the frame end; start is still ignored here.
                DRAIN: if (done_q) begin
                    state_q  <= IDLE;
                    rd_row_q <= '0;
                    rd_col_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Stage 1 tracks the request while memory answers; stage 2 captures the pooled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_vld_q   <= 1'b0;
            p1_row_q   <= '0;
            p1_col_q   <= '0;
            save_en_q  <= 1'b0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_data_q <= '0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            p1_vld_q   <= rd_en_q;
            p1_row_q   <= rd_en_q ? rd_row_q : '0;
            p1_col_q   <= rd_en_q ? rd_col_q : '0;
            save_en_q  <= p1_vld_q;
            out_row_q  <= p1_vld_q ? p1_row_q : '0;
            out_col_q  <= p1_vld_q ? p1_col_q : '0;
            out_data_q <= p1_vld_q ? pool_d : out_data_q;
            first_q    <= p1_vld_q && p1_row_q == '0 && p1_col_q == '0;
            done_q     <= p1_vld_q && p1_row_q == LAST_R && p1_col_q == LAST_C;
        end
    end
    assign rd_en     = rd_en_q;
    assign rd_row    = rd_row_q;
    assign rd_col    = rd_col_q;
    assign save_en   = save_en_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_data  = out_data_q;
    assign busy      = state_q != IDLE;
    assign first_out = first_q;
    assign done      = done_q;
endmodule

// File: tb/tb_cnn_pool2x2_param.sv
// tb_cnn_pool2x2_param: scoreboard bench for cnn_pool2x2_param over 2x2, 2x2+ReLU, 1x1 and 8x8 maps.
`timescale 1ns/1ps
module tb_cnn_pool2x2_param;
    typedef struct {
        logic [15:0]  row;
        logic [15:0]  col;
        logic [127:0] data;
        logic         first;
        logic         last;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst;
    logic         pool_mode;
    logic         st[4];
    logic [127:0] in_ee, in_eo, in_oe, in_oo;
    logic         rd_en[4], save_en[4], busy[4], first_out[4], done[4];
    logic [15:0]  rd_row[4], rd_col[4], out_row[4], out_col[4];
    logic [127:0] out_data[4];
    logic [127:0] mem_ee[64], mem_eo[64], mem_oe[64], mem_oo[64], exp_mem[64];
    exp_t         q[4][$];
    int           sel = 0;
    int           checks = 0;
    int           errors = 0;
    always #5 clk = ~clk;
    function automatic int dim(input int g);
        return g == 2 ? 1 : g == 3 ? 8 : 2;
    endfunction
    // Instance 0: 2x2, 1: 2x2 with ReLU, 2: 1x1, 3: 8x8.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        cnn_pool2x2_param #(
            .CH(8), .DW(16), .AW(16),
            .OUT_ROWS(g == 2 ? 1 : g == 3 ? 8 : 2),
            .OUT_COLS(g == 2 ? 1 : g == 3 ? 8 : 2),
            .RELU(g == 1 ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst), .start(st[g]), .pool_mode(pool_mode),
            .in_ee(in_ee), .in_eo(in_eo), .in_oe(in_oe), .in_oo(in_oo),
            .rd_en(rd_en[g]), .rd_row(rd_row[g]), .rd_col(rd_col[g]),
            .save_en(save_en[g]), .out_row(out_row[g]), .out_col(out_col[g]),
            .out_data(out_data[g]), .busy(busy[g]), .first_out(first_out[g]), .done(done[g])
        );
    end
    // Source buffer with one-cycle read latency, answering the instance under test.
    always @(posedge clk) begin
        if (rd_en[sel]) begin
            in_ee <= mem_ee[int'(rd_row[sel]) * dim(sel) + int'(rd_col[sel])];
            in_eo <= mem_eo[int'(rd_row[sel]) * dim(sel) + int'(rd_col[sel])];
            in_oe <= mem_oe[int'(rd_row[sel]) * dim(sel) + int'(rd_col[sel])];
            in_oo <= mem_oo[int'(rd_row[sel]) * dim(sel) + int'(rd_col[sel])];
        end
    end
    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction
    for (genvar g = 0; g < 4; g++) begin : g_mon
        exp_t e;
        always @(negedge clk) begin
            if (save_en[g]) begin
                if (q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected save_en on dut %0d at (%0d,%0d)", g, out_row[g], out_col[g]);
                end else begin
                    e = q[g].pop_front();
                    chk("out_row", out_row[g], e.row);
                    chk("out_col", out_col[g], e.col);
                    chk("out_data", out_data[g], e.data);
                    chk("first_out", first_out[g], e.first);
                    chk("done", done[g], e.last);
                end
            end
        end
    end
    // Independent reference: integer max and floor division without shifts.
    function automatic logic [127:0] model(input bit m, input bit relu,
                                           input logic [127:0] a, b, c, d);
        logic [127:0] w;
        int v[4];
        int mx, s, r;
        for (int k = 0; k < 8; k++) begin
            v[0] = int'($signed(a[k*16 +: 16]));
            v[1] = int'($signed(b[k*16 +: 16]));
            v[2] = int'($signed(c[k*16 +: 16]));
            v[3] = int'($signed(d[k*16 +: 16]));
            mx = v[0];
            s = 0;
            for (int i = 0; i < 4; i++) begin
                if (v[i] > mx) mx = v[i];
                s += v[i];
            end
            r = m ? (s >= 0 ? s / 4 : -((-s + 3) / 4)) : mx;
            if (relu && r < 0) r = 0;
            w[k*16 +: 16] = r[15:0];
        end
        return w;
    endfunction
    task automatic set_dir(input int p, input logic [15:0] a, b, c, d, input logic [15:0] e);
        mem_ee[p] = {8{a}};
        mem_eo[p] = {8{b}};
        mem_oe[p] = {8{c}};
        mem_oo[p] = {8{d}};
        exp_mem[p] = {8{e}};
    endtask
    task automatic set_rand(input int p, input bit m, input bit relu);
        mem_ee[p] = {$urandom, $urandom, $urandom, $urandom};
        mem_eo[p] = {$urandom, $urandom, $urandom, $urandom};
        mem_oe[p] = {$urandom, $urandom, $urandom, $urandom};
        mem_oo[p] = {$urandom, $urandom, $urandom, $urandom};
        exp_mem[p] = model(m, relu, mem_ee[p], mem_eo[p], mem_oe[p], mem_oo[p]);
    endtask
    // Called at a negedge; returns at the negedge of cycle N+3 so the next frame can start there.
    task automatic frame(input int id, input bit mode, input bit restart);
        int c, n;
        exp_t e;
        c = dim(id);
        n = c * c;
        sel = id;
        pool_mode = mode;
        for (int p = 0; p < n; p++) begin
            e.row = 16'(p / c);
            e.col = 16'(p % c);
            e.data = exp_mem[p];
            e.first = p == 0;
            e.last = p == n - 1;
            q[id].push_back(e);
        end
        st[id] = 1'b1;
        @(posedge clk);
        for (int cy = 1; cy <= n + 3; cy++) begin
            @(negedge clk);
            st[id] = restart && (cy == 2 || cy == n + 2);
            if (restart && cy == 2) pool_mode = ~mode;
            chk("rd_en", rd_en[id], cy <= n);
            if (cy <= n) begin
                chk("rd_row", rd_row[id], 128'((cy - 1) / c));
                chk("rd_col", rd_col[id], 128'((cy - 1) % c));
            end
            chk("save_en timing", save_en[id], cy >= 3 && cy <= n + 2);
            chk("busy", busy[id], cy <= n + 2);
            chk("first_out timing", first_out[id], cy == 3);
            chk("done timing", done[id], cy == n + 2);
        end
        st[id] = 1'b0;
    endtask
    task automatic zero_outs(input int g);
        chk("rst rd_en", rd_en[g], 0);
        chk("rst rd_row", rd_row[g], 0);
        chk("rst rd_col", rd_col[g], 0);
        chk("rst save_en", save_en[g], 0);
        chk("rst out_row", out_row[g], 0);
        chk("rst out_col", out_col[g], 0);
        chk("rst out_data", out_data[g], 0);
        chk("rst busy", busy[g], 0);
        chk("rst first_out", first_out[g], 0);
        chk("rst done", done[g], 0);
    endtask
    initial begin
        rst = 1'b1;
        pool_mode = 1'b0;
        for (int g = 0; g < 4; g++) st[g] = 1'b0;
        in_ee = '0; in_eo = '0; in_oe = '0; in_oo = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) zero_outs(g);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        // Max mode, hand-computed quads replicated across all channels.
        set_dir(0, 5, -3, 7, 2, 16'h0007);
        set_dir(1, -1, -2, -3, -4, 16'hFFFF);
        set_dir(2, 16'h7FFF, 16'h8000, 0, 1, 16'h7FFF);
        set_dir(3, -100, -50, -75, -200, 16'hFFCE);
        frame(0, 1'b0, 1'b0);
        // Average mode: floor of negative, rounding down of positive, both extremes.
        set_dir(0, -1, -2, -3, -4, 16'hFFFD);
        set_dir(1, 1, 2, 3, 5, 16'h0002);
        set_dir(2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_dir(3, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        frame(0, 1'b1, 1'b0);
        // Re-pulsed start and mid-frame mode flip, then a back-to-back frame at N+3.
        for (int p = 0; p < 4; p++) set_rand(p, 1'b1, 1'b0);
        frame(0, 1'b1, 1'b1);
        for (int p = 0; p < 4; p++) set_rand(p, 1'b0, 1'b0);
        frame(0, 1'b0, 1'b0);
        // ReLU instance.
        set_dir(0, -5, -6, -7, -8, 16'h0000);
        set_dir(1, 3, -9, 1, 0, 16'h0003);
        set_rand(2, 1'b0, 1'b1);
        set_rand(3, 1'b0, 1'b1);
        frame(1, 1'b0, 1'b0);
        set_dir(0, 4, 4, 4, -4, 16'h0002);
        set_dir(1, -1, -2, -3, -4, 16'h0000);
        set_rand(2, 1'b1, 1'b1);
        set_rand(3, 1'b1, 1'b1);
        frame(1, 1'b1, 1'b0);
        // 1x1 map: first_out and done coincide.
        set_dir(0, 10, 20, -30, 40, 16'h0028);
        frame(2, 1'b0, 1'b0);
        // 8x8 frame interrupted by reset in cycle 4.
        for (int p = 0; p < 64; p++) set_rand(p, 1'b0, 1'b0);
        sel = 3;
        pool_mode = 1'b0;
        for (int p = 0; p < 64; p++) begin
            exp_t e;
            e.row = 16'(p / 8);
            e.col = 16'(p % 8);
            e.data = exp_mem[p];
            e.first = p == 0;
            e.last = p == 63;
            q[3].push_back(e);
        end
        st[3] = 1'b1;
        @(posedge clk);
        #1 st[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 zero_outs(3);
        @(posedge clk);
        #1 rst = 1'b0;
        q[3].delete();
        repeat (20) begin
            @(negedge clk);
            chk("post-rst save_en", save_en[3], 0);
            chk("post-rst done", done[3], 0);
            chk("post-rst busy", busy[3], 0);
        end
        for (int p = 0; p < 64; p++) set_rand(p, 1'b1, 1'b0);
        frame(3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (q[g].size() != 0) begin
                errors++;
                $display("FAIL leftover words dut %0d: got %0d expected 0", g, q[g].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cnn_pool2x2_param.md
# cnn_pool2x2_param

Parametrised 2x2/stride-2 pooling stage for the CNN pipeline. It sits between a conv layer's output pixel buffer and the next layer's input buffer. After `start`, it walks the pooled output map in row-major order and issues read addresses for the four-pixel quad of each output position. It pools CH channels per quad in parallel, using max or average selected at run time with optional ReLU, and emits each pooled word with its destination row/column.

## Interface
Parameters:
- CH, 8, channels packed per word; channel k occupies bits [k*DW +: DW]
- DW, 16, bits per channel, signed two's complement
- OUT_ROWS, 8, pooled map rows (input map is 2*OUT_ROWS rows)
- OUT_COLS, 8, pooled map columns
- AW, 16, address/counter width; must satisfy 2^AW > max(OUT_ROWS, OUT_COLS)
- RELU, 0, 1 = clamp negative pooled results to 0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: source buffer full, begin frame
- pool_mode  in  1  0 = max, 1 = average; sampled with accepted start
- in_ee, in_eo, in_oe, in_oo  in  CH*DW  quad pixels (even/odd row, even/odd col), valid one cycle after rd_en
- rd_en  out  1  read request for the quad at (rd_row, rd_col)
- rd_row, rd_col  out  AW  pooled-map coordinates of requested quad
- save_en  out  1  out_data valid; write to (out_row, out_col)
- out_row, out_col  out  AW  destination coordinates
- out_data  out  CH*DW  pooled word
- busy  out  1  frame in progress
- first_out  out  1  pulse with first save_en of a frame
- done  out  1  pulse with last save_en of a frame

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - All outputs low/zero; counters cleared.
  - `start`=1 -> READ; `pool_mode` latched into `mode_q`.
- READ:
  - `rd_en`=1 every cycle.
  - `rd_col` increments each cycle. At OUT_COLS-1 it wraps to 0 and `rd_row` increments.
  - After the request for (OUT_ROWS-1, OUT_COLS-1), go to DRAIN.
- DRAIN:
  - `rd_en`=0; `rd_row`/`rd_col` hold the last request.
  - Waits for the 2-deep valid pipe to empty.
  - Goes to IDLE in the cycle `done` is asserted.
- `start` is ignored outside IDLE, including in the `done` cycle.
- Pipeline (2 stages):
  - `rd_en`, `rd_row` and `rd_col` are delayed two cycles to `save_en`, `out_row` and `out_col`.
  - `out_data` is registered from the combinational pool of `in_*` sampled in the cycle after `rd_en`.
- Per channel, operands are the DW-bit slices of `in_ee`, `in_eo`, `in_oe`, `in_oo`:
  - Max mode: signed maximum of the four; ties are irrelevant.
  - Average mode: sign-extend the four operands to DW+2 bits, sum them, arithmetic-shift right 2 (floor), truncate to DW. The result always fits.
  - If RELU=1, a negative result becomes 0, applied after pooling.
- `out_data` holds its last value while `save_en`=0.
- `busy`=1 in READ and DRAIN.
- `first_out`=1 when `save_en`=1 and `out_row`=`out_col`=0.
- `done`=1 when `save_en`=1 and `out_row`=OUT_ROWS-1 and `out_col`=OUT_COLS-1.
- If OUT_ROWS=OUT_COLS=1, `first_out` and `done` assert in the same cycle.

## Timing
- Let N = OUT_ROWS*OUT_COLS, and let `start` be sampled at edge 0.
- Cycles 1..N: READ, `rd_en`=1.
- Cycles N+1, N+2: DRAIN.
- Cycles 3..N+2: `save_en`=1, one word per cycle with no gaps.
- `first_out` at cycle 3; `done` at cycle N+2.
- `busy`=1 in cycles 1..N+2; IDLE from cycle N+3.
- The earliest next accepted `start` is at cycle N+3.
- Latency from a `rd_en` to its `save_en` is exactly 2 cycles; the source memory must have exactly 1-cycle read latency.
- Reset: any assertion, including mid-frame, forces IDLE immediately.
  - Zeroes `rd_en`, `rd_row`, `rd_col`, `save_en`, `out_row`, `out_col`, `out_data`, `busy`, `first_out`, `done`, the valid pipe and `mode_q`.
  - No partial-frame completion occurs after release.
- `pool_mode` changes during a frame have no effect.

## Test plan
- OUT_ROWS=OUT_COLS=2, max mode; quad channel 0 = (5, -3, 7, 2) -> `out_data[15:0]`=7.
  - Check address order (0,0),(0,1),(1,0),(1,1).
  - Check `save_en` on cycles 3-6, `first_out` at cycle 3, `done` at cycle 6, `busy` low at cycle 7.
- Average mode, quads (-1,-2,-3,-4) and (1,2,3,5) -> -3 (0xFFFD) and 2; all-0x7FFF -> 0x7FFF; all-0x8000 -> 0x8000.
- RELU=1, max of (-5,-6,-7,-8) -> 0; avg of (4,4,4,-4) -> 2. Independent per-channel values across all 8 channels are pooled correctly.
- `start` re-pulsed at cycles 2 and N+2, and `pool_mode` toggled mid-frame -> ignored.
  - Exactly N `save_en` pulses occur, all in the latched mode.
  - `start` at N+3 begins a new frame.
- `rst` asserted at cycle 4 of an 8x8 frame -> all outputs 0 in that cycle; no `save_en` or `done` until a new `start`; the following frame completes normally.
- OUT_ROWS=1, OUT_COLS=1 -> single `save_en` at cycle 3 with `first_out`=`done`=1.
